operand_regfile: RTL

- Register file directly upstream of the ALU: supplies opA, opB and opaddrA for the execute step.
- Holds 2^ADDR_WIDTH general registers; register 0 reads as zero.
- Provides two combinational read ports and one synchronous write port, with write-to-read bypass, so a result written back in cycle N is visible to a read in the same cycle.
- Also latches the ALU's carry-out and a zero flag into a status register for later branch/condition use.

---
 rtl/operand_regfile.sv | 105 ++++++++++
 1 files changed

// File: rtl/operand_regfile.sv
// Operand register file feeding the ALU: two combinational read ports with
// write-to-read bypass, one synchronous write port, and a carry/zero status
// register. Register 0 is hardwired to zero.
module operand_regfile #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned D_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] rdaddrA,
   input  logic [ADDR_WIDTH-1:0] rdaddrB,
   output logic [D_WIDTH-1:0]    opA,
   output logic [D_WIDTH-1:0]    opB,
   output logic [ADDR_WIDTH-1:0] opaddrA,
   input  logic                  wrEn,
   input  logic [ADDR_WIDTH-1:0] wrAddr,
   input  logic [D_WIDTH-1:0]    wrData,
   input  logic                  flagEn,
   input  logic                  aluCout,
   input  logic [D_WIDTH-1:0]    aluResult,
   output logic                  carryFlag,
   output logic                  zeroFlag,
   output logic [7:0]            wrCount
);

   localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_WIDTH = 8;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Entry 0 is never written, so it is a constant zero and drops out in synthesis.
   logic [D_WIDTH-1:0]   r_regs [NUM_REGS];
   logic [CNT_WIDTH-1:0] r_wr_count;
   logic                 r_carry;
   logic                 r_zero;

   logic                 w_wr_commit;
   logic [D_WIDTH-1:0]   w_op_a;
   logic [D_WIDTH-1:0]   w_op_b;

   // A write commits only when enabled and not targeting the zero register.
   assign w_wr_commit = wrEn && (wrAddr != '0);

   // Register storage; async reset clears every entry immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_commit) begin
         r_regs[wrAddr] <= wrData;
      end
   end

   // Saturating count of committed writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_count <= '0;
      end else if (w_wr_commit && (r_wr_count != CNT_MAX)) begin
         r_wr_count <= r_wr_count + CNT_WIDTH'(1);
      end
   end

   // Status flags captured from the ALU, independent of the write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
      end else if (flagEn) begin
         r_carry <= aluCout;
         r_zero  <= (aluResult == '0);
      end
   end

   // Read port A: zero register, then same-cycle bypass, then storage.
   always_comb begin
      w_op_a = '0;
      if (rdaddrA == '0) begin
         w_op_a = '0;
      end else if (wrEn && (wrAddr == rdaddrA)) begin
         w_op_a = wrData;
      end else begin
         w_op_a = r_regs[rdaddrA];
      end
   end

   // Read port B: same priority as port A.
   always_comb begin
      w_op_b = '0;
      if (rdaddrB == '0) begin
         w_op_b = '0;
      end else if (wrEn && (wrAddr == rdaddrB)) begin
         w_op_b = wrData;
      end else begin
         w_op_b = r_regs[rdaddrB];
      end
   end

   assign opA       = w_op_a;
   assign opB       = w_op_b;
   assign opaddrA   = rdaddrA;
   assign carryFlag = r_carry;
   assign zeroFlag  = r_zero;
   assign wrCount   = r_wr_count;

endmodule
